jt12_mmr_writer: RTL and testbench

- Bus-master side of the JT12 register port: drives `write`/`addr`/`din` and samples `busy`.
- Accepts queued (bank, register, value) requests from a host-side sequencer, such as a VGM player or the test harness.
- Converts each request into the chip's two-phase toggle protocol: an address write, then a data write.
- Waits for the chip to finish each access and skips redundant address phases.

---
 rtl/jt12_mmr_writer.sv | 173 +++++++++++++++++
 tb/tb_jt12_mmr_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_mmr_writer.sv
// jt12_mmr_writer
// Bus-master for the JT12 register port. Host requests (bank, register,
// value) are queued in a small FIFO and replayed to the chip as the
// two-phase toggle protocol: an address access followed by a data access.
// Each access is a level change on `write`. After every toggle the writer
// waits MIN_GAP cycles, then for `busy` low, before issuing the next access.
// When SKIP_ADDR is set, the address phase is dropped if the chip already
// holds the requested bank/register from the previous address write.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   req_valid  request offered by the host
//   req_ready  FIFO can accept (registered, equals !full)
//   req_bank   0 = ch1-3/global, 1 = ch4-6
//   req_reg    register number
//   req_data   value to write
//   write      access strobe, one toggle per access
//   addr       {bank, phase}: phase 0 = address, 1 = data
//   din        register number (address phase) or value (data phase)
//   busy       chip busy
//   level      FIFO occupancy
//   idle       FSM idle and FIFO empty
module jt12_mmr_writer #(
   parameter int DEPTH     = 4,
   parameter int MIN_GAP   = 2,
   parameter int SKIP_ADDR = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_bank,
   input  logic [7:0]               req_reg,
   input  logic [7:0]               req_data,
   output logic                     write,
   output logic [1:0]               addr,
   output logic [7:0]               din,
   input  logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     idle
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [GW-1:0] GAP_LD   = GW'(MIN_GAP);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_A, S_WAIT_D} state_t;

   // Request FIFO: entry = {bank, reg, data}
   logic [16:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ready_q;
   logic          push, pop;

   // Writer state
   state_t        state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          write_q, write_d;
   logic [1:0]    addr_q, addr_d;
   logic [7:0]    din_q, din_d;
   logic [8:0]    cache_q, cache_d;
   logic          cvld_q, cvld_d;

   logic          empty, hit, decide, issue_data;
   logic [16:0]   head;

   assign push  = req_valid && ready_q;
   assign empty = (cnt_q == '0);
   // Head is read straight from the array so a request costs no extra cycle.
   assign head  = mem_q[rd_ptr_q];
   assign hit   = (SKIP_ADDR != 0) && cvld_q && (cache_q == head[16:8]);
   assign cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      write_d    = write_q;
      addr_d     = addr_q;
      din_d      = din_q;
      cache_d    = cache_q;
      cvld_d     = cvld_q;
      pop        = 1'b0;
      decide     = 1'b0;
      issue_data = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!empty && !busy) decide = 1'b1;
         end
         S_WAIT_A: begin
            if (gap_q != '0)  gap_d = gap_q - GW'(1);
            else if (!busy)   issue_data = 1'b1;
         end
         S_WAIT_D: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GW'(1);
            end else if (!busy) begin
               // Chain straight into the next request without an idle cycle.
               if (!empty) decide  = 1'b1;
               else        state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (decide) begin
         if (hit) begin
            issue_data = 1'b1;
         end else begin
            write_d = ~write_q;
            addr_d  = {head[16], 1'b0};
            din_d   = head[15:8];
            cache_d = head[16:8];
            cvld_d  = 1'b1;
            gap_d   = GAP_LD;
            state_d = S_WAIT_A;
         end
      end

      if (issue_data) begin
         write_d = ~write_q;
         addr_d  = {head[16], 1'b1};
         din_d   = head[7:0];
         gap_d   = GAP_LD;
         pop     = 1'b1;
         state_d = S_WAIT_D;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {req_bank, req_reg, req_data};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         state_q  <= S_IDLE;
         gap_q    <= '0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         cache_q  <= '0;
         cvld_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q    <= cnt_d;
         // Ready reflects the occupancy after this edge, so it is a plain flop.
         ready_q  <= (cnt_d != FULL_CNT);
         state_q  <= state_d;
         gap_q    <= gap_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         cache_q  <= cache_d;
         cvld_q   <= cvld_d;
      end
   end

   assign req_ready = ready_q;
   assign write     = write_q;
   assign addr      = addr_q;
   assign din       = din_q;
   assign level     = cnt_q;
   assign idle      = (state_q == S_IDLE) && empty;

endmodule

// File: tb/tb_jt12_mmr_writer.sv
// Bench for jt12_mmr_writer. Two instances: one with the address skip
// enabled, one with it disabled. Expected toggles are queued as
// {addr, din} when requests are driven and compared as each toggle appears.
module tb_jt12_mmr_writer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, req_valid1 = 1'b0;
   logic       req_bank = 1'b0;
   logic [7:0] req_reg = 8'h00, req_data = 8'h00;
   logic       busy = 1'b0;

   logic       req_ready, write, idle;
   logic [1:0] addr;
   logic [7:0] din;
   logic [2:0] level;
   logic       req_ready1, write1, idle1;
   logic [1:0] addr1;
   logic [7:0] din1;
   logic [2:0] level1;

   int         checks = 0, errors = 0, cyc = 0;
   bit         ign = 1'b0;
   logic [9:0] exp0[$], exp1[$];
   int         tcyc[$];
   logic       pw = 1'b0, pw1 = 1'b0;
   logic [9:0] e0, e1;

   jt12_mmr_writer #(.DEPTH(4), .MIN_GAP(2), .SKIP_ADDR(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_bank(req_bank), .req_reg(req_reg), .req_data(req_data),
      .write(write), .addr(addr), .din(din), .busy(busy),
      .level(level), .idle(idle));

   jt12_mmr_writer #(.DEPTH(4), .MIN_GAP(2), .SKIP_ADDR(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_bank(req_bank), .req_reg(req_reg), .req_data(req_data),
      .write(write1), .addr(addr1), .din(din1), .busy(1'b0),
      .level(level1), .idle(idle1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Toggle monitors: each level change on write must match the queue head.
   always @(negedge clk) begin
      if (write !== pw && !ign) begin
         tcyc.push_back(cyc);
         chk("tog_expected", exp0.size() != 0, 1);
         if (exp0.size() != 0) begin
            e0 = exp0.pop_front();
            chk("tog_addr", addr, e0[9:8]);
            chk("tog_din", din, e0[7:0]);
         end
      end
      pw <= write;
   end

   always @(negedge clk) begin
      if (write1 !== pw1 && !ign) begin
         chk("tog1_expected", exp1.size() != 0, 1);
         if (exp1.size() != 0) begin
            e1 = exp1.pop_front();
            chk("tog1_addr", addr1, e1[9:8]);
            chk("tog1_din", din1, e1[7:0]);
         end
      end
      pw1 <= write1;
   end

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic ex0(input logic [1:0] a, input logic [7:0] d);
      exp0.push_back({a, d});
   endtask

   task automatic ex1(input logic [1:0] a, input logic [7:0] d);
      exp1.push_back({a, d});
   endtask

   task automatic push(input logic b, input logic [7:0] r, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_bank = b; req_reg = r; req_data = d;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("push_accepted", n < 100, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic push1(input logic b, input logic [7:0] r, input logic [7:0] d);
      @(negedge clk);
      req_valid1 = 1'b1; req_bank = b; req_reg = r; req_data = d;
      @(posedge clk); #1;
      req_valid1 = 1'b0;
   endtask

   task automatic wait_tog(input int n);
      int k = 0;
      while (tcyc.size() < n && k < 200) begin
         step();
         k++;
      end
      chk("tog_count", tcyc.size(), n);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(idle && exp0.size() == 0) && k < 300) begin
         step();
         k++;
      end
      chk("idle_reached", idle && exp0.size() == 0, 1);
   endtask

   task automatic wait_idle1();
      int k = 0;
      while (!(idle1 && exp1.size() == 0) && k < 300) begin
         step();
         k++;
      end
      chk("idle1_reached", idle1 && exp1.size() == 0, 1);
   endtask

   initial begin
      int base, fall;

      // Reset state
      repeat (2) @(posedge clk);
      step();
      chk("rst_write", write, 0);
      chk("rst_addr", addr, 0);
      chk("rst_din", din, 0);
      chk("rst_level", level, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_idle", idle, 1);
      rst_n = 1'b1;
      step();

      // Single write
      base = tcyc.size();
      ex0(2'b00, 8'h28); ex0(2'b01, 8'hF1);
      push(1'b0, 8'h28, 8'hF1);
      wait_tog(base + 1);
      chk("single_write_hi", write, 1);
      wait_tog(base + 2);
      chk("single_write_lo", write, 0);
      chk("single_spacing", tcyc[base + 1] - tcyc[base], 3);
      step(); step();
      chk("single_not_idle", idle, 0);
      step();
      chk("single_idle", idle, 1);

      // Address skip
      base = tcyc.size();
      ex0(2'b00, 8'hA4); ex0(2'b01, 8'h22); ex0(2'b01, 8'h23);
      push(1'b0, 8'hA4, 8'h22);
      push(1'b0, 8'hA4, 8'h23);
      wait_idle();
      chk("skip_tog_count", tcyc.size(), base + 3);
      chk("skip_spacing", tcyc[base + 2] - tcyc[base + 1], 3);

      // No skip when disabled
      ex1(2'b00, 8'hA4); ex1(2'b01, 8'h22); ex1(2'b00, 8'hA4); ex1(2'b01, 8'h23);
      push1(1'b0, 8'hA4, 8'h22);
      push1(1'b0, 8'hA4, 8'h23);
      wait_idle1();

      // Bank change
      ex0(2'b00, 8'h30); ex0(2'b01, 8'h01); ex0(2'b10, 8'h30); ex0(2'b11, 8'h02);
      push(1'b0, 8'h30, 8'h01);
      push(1'b1, 8'h30, 8'h02);
      wait_idle();

      // Busy stall
      base = tcyc.size();
      ex0(2'b00, 8'h40); ex0(2'b01, 8'h55);
      push(1'b0, 8'h40, 8'h55);
      wait_tog(base + 1);
      busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_no_toggle", tcyc.size(), base + 1);
         chk("stall_addr", addr, 2'b00);
         chk("stall_din", din, 8'h40);
      end
      busy = 1'b0;
      fall = cyc;
      wait_tog(base + 2);
      chk("stall_release", tcyc[base + 1], fall + 1);
      wait_idle();

      // Backpressure
      busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ex0(2'b00, 8'h50 + 8'(i));
         ex0(2'b01, 8'hC0 + 8'(i));
      end
      for (int i = 0; i < 4; i++) push(1'b0, 8'h50 + 8'(i), 8'hC0 + 8'(i));
      chk("bp_level_full", level, 4);
      chk("bp_ready_low", req_ready, 0);
      req_valid = 1'b1; req_bank = 1'b0; req_reg = 8'h54; req_data = 8'hC4;
      repeat (3) step();
      chk("bp_level_held", level, 4);
      chk("bp_ready_held", req_ready, 0);
      busy = 1'b0;
      push(1'b0, 8'h54, 8'hC4);
      wait_idle();

      // Reset mid-operation
      base = tcyc.size();
      ex0(2'b00, 8'h60);
      push(1'b0, 8'h60, 8'h77);
      wait_tog(base + 1);
      ign = 1'b1;
      rst_n = 1'b0;
      step();
      chk("mid_rst_write", write, 0);
      chk("mid_rst_addr", addr, 0);
      chk("mid_rst_din", din, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_idle", idle, 1);
      chk("mid_rst_ready", req_ready, 1);
      rst_n = 1'b1;
      step();
      ign = 1'b0;
      ex0(2'b00, 8'h60); ex0(2'b01, 8'h78);
      push(1'b0, 8'h60, 8'h78);
      wait_idle();

      chk("exp0_drained", exp0.size(), 0);
      chk("exp1_drained", exp1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
